// File: rtl/usrt_rx_deframer.sv
// USRT receive deframer: samples one bit per i_Pclk edge, strips start/parity/stop,
// and presents the data word with a one-cycle valid strobe plus parity/framing error flags.
module usrt_rx_deframer #(
  parameter int DATA_BITS = 8
) (
  input  logic                 i_Pclk,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx,
  input  logic [1:0]           i_Parity,
  output logic [DATA_BITS-1:0] o_Data,
  output logic                 o_Valid,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DATA    = 3'd1;
  localparam logic [2:0] ST_PARITY  = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  logic [2:0]           state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [1:0]           mode_q,    mode_d;
  logic [DATA_BITS-1:0] shreg_q,   shreg_d;
  logic                 par_bit_q, par_bit_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 valid_q,   valid_d;
  logic                 perr_q,    perr_d;
  logic                 ferr_q,    ferr_d;

  logic par_en;
  logic par_fail;

  // Modes 00 and 11 both mean "no parity bit on the wire".
  assign par_en   = (mode_q == 2'b01) || (mode_q == 2'b10);
  assign par_fail = par_en & (^shreg_q ^ par_bit_q ^ mode_q[0]);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    shreg_d   = shreg_q;
    par_bit_d = par_bit_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    case (state_q)
      ST_IDLE: begin
        if (!i_Rx) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          mode_d  = i_Parity;
        end
      end
      ST_DATA: begin
        shreg_d                = shreg_q >> 1;
        shreg_d[DATA_BITS-1]   = i_Rx;
        cnt_d                  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
          state_d = par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        par_bit_d = i_Rx;
        state_d   = ST_STOP;
      end
      ST_STOP: begin
        data_d  = shreg_q;
        perr_d  = par_fail;
        ferr_d  = ~i_Rx;
        valid_d = 1'b1;
        // A low stop bit must not be mistaken for the next start bit.
        state_d = i_Rx ? ST_IDLE : ST_RECOVER;
      end
      ST_RECOVER: begin
        if (i_Rx) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the shift register is
  // reset along with everything else so a mid-frame reset leaves no partial word behind.
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mode_q    <= 2'b00;
      shreg_q   <= '0;
      par_bit_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      shreg_q   <= shreg_d;
      par_bit_q <= par_bit_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign o_Data       = data_q;
  assign o_Valid      = valid_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Busy       = (state_q == ST_DATA) || (state_q == ST_PARITY) || (state_q == ST_STOP);

endmodule

// File: tb/tb_usrt_rx_deframer.sv
// Testbench for usrt_rx_deframer: table-driven frames plus hand-written corner sequences,
// with a scoreboard queue checked whenever o_Valid strobes.
module tb_usrt_rx_deframer;

  logic       i_Pclk = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_Rx = 1'b1;
  logic [1:0] i_Parity = 2'b00;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       o_Parity_Err;
  logic       o_Frame_Err;
  logic       o_Busy;

  usrt_rx_deframer #(.DATA_BITS(8)) dut (
    .i_Pclk       (i_Pclk),
    .i_Rst_n      (i_Rst_n),
    .i_Rx         (i_Rx),
    .i_Parity     (i_Parity),
    .o_Data       (o_Data),
    .o_Valid      (o_Valid),
    .o_Parity_Err (o_Parity_Err),
    .o_Frame_Err  (o_Frame_Err),
    .o_Busy       (o_Busy)
  );

  always #5 i_Pclk = ~i_Pclk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       par_bit;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         edge_idx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  vec_t vecs[8];

  always @(posedge i_Pclk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding frame, including its timing.
  always @(negedge i_Pclk) begin
    if (i_Rst_n && o_Valid) begin
      check("valid_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("data", o_Data, e.data);
        check("parity_err", o_Parity_Err, e.perr);
        check("frame_err", o_Frame_Err, e.ferr);
        check("valid_edge", edge_n, e.edge_idx);
      end
    end
  end

  task automatic drive_bit(input logic b);
    i_Rx = b;
    @(negedge i_Pclk);
  endtask

  // Drives one full frame starting at the current negedge; scrambles i_Parity after the
  // start bit so the deframer must rely on the mode latched at the start bit.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input logic pbit,
                            input logic stop, input logic eperr, input logic eferr);
    exp_t e;
    int   par_en;
    par_en     = (mode == 2'b01 || mode == 2'b10) ? 1 : 0;
    e.data     = d;
    e.perr     = eperr;
    e.ferr     = eferr;
    e.edge_idx = edge_n + 1 + 8 + par_en + 1;
    sb.push_back(e);
    i_Parity = mode;
    drive_bit(1'b0);
    i_Parity = ~mode;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_en != 0) drive_bit(pbit);
    drive_bit(stop);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge i_Pclk);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h03, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hC3, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h96, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{8'hA5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h5A, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge i_Pclk);
    check("rst_data", o_Data, 0);
    check("rst_valid", o_Valid, 0);
    check("rst_perr", o_Parity_Err, 0);
    check("rst_ferr", o_Frame_Err, 0);
    check("rst_busy", o_Busy, 0);
    i_Rst_n = 1'b1;
    repeat (2) @(negedge i_Pclk);

    // Table-driven frames, back-to-back except after a bad stop bit
    foreach (vecs[k]) begin
      send_frame(vecs[k].data, vecs[k].mode, vecs[k].par_bit, vecs[k].stop,
                 vecs[k].exp_perr, vecs[k].exp_ferr);
      if (!vecs[k].stop) drive_bit(1'b1);
    end
    wait_drain();

    // Frame error with line held low: no start detection until the line returns high
    send_frame(8'h03, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("recover_busy", o_Busy, 0);
      drive_bit(1'b0);
    end
    drive_bit(1'b1);
    send_frame(8'h03, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check("after_recover_ferr", o_Frame_Err, 0);

    // Reset mid-frame after four data bits
    send_frame(8'hE7, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    i_Parity = 2'b01;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    check("midframe_busy", o_Busy, 1);
    i_Rst_n = 1'b0;
    #1;
    check("midrst_data", o_Data, 0);
    check("midrst_valid", o_Valid, 0);
    check("midrst_perr", o_Parity_Err, 0);
    check("midrst_ferr", o_Frame_Err, 0);
    check("midrst_busy", o_Busy, 0);
    i_Rx = 1'b1;
    @(negedge i_Pclk);
    i_Rst_n = 1'b1;
    repeat (3) @(negedge i_Pclk);
    check("post_rst_valid", o_Valid, 0);
    send_frame(8'h3C, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain();

    // Loopback of every byte in odd and even modes
    for (int m = 1; m <= 2; m++) begin
      for (int d = 0; d < 256; d++) begin
        logic [7:0] b;
        logic       p;
        b = d[7:0];
        p = (m == 1) ? ~(^b) : (^b);
        send_frame(b, m[1:0], p, 1'b1, 1'b0, 1'b0);
      end
    end
    wait_drain();
    check("loopback_perr", o_Parity_Err, 0);
    check("loopback_ferr", o_Frame_Err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
